// File: rtl/spi_arb_master_if.sv
// spi_arb_master_if: requester handshake and SPI pins of spi_arb_master
interface spi_arb_master_if;
  logic       req0, req1, rw0, rw1, slv0, slv1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, cs, mosi, busy, last_gnt;
  modport master (
    input  req0, req1, rw0, rw1, slv0, slv1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, cs, mosi, busy, last_gnt
  );
  modport slave (
    output req0, req1, rw0, rw1, slv0, slv1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, cs, mosi, busy, last_gnt
  );
endinterface

// File: rtl/spi_arb_master.sv
// spi_arb_master: two-requester SPI frame master; SPI_ARB_RR_EN selects round-robin ties, else requester 0 wins
module spi_arb_master #(
  parameter int GAP_CYCLES = 2
) (
  input logic              sclk,
  input logic              reset,
  spi_arb_master_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2;
  logic [1:0]  state;
  logic [11:0] sr;
  logic [3:0]  bit_cnt, gap_cnt;
  logic        cs, mosi, ack0, ack1, last_gnt;
  logic        tie, sel, s_rw, s_slv;
  logic [2:0]  s_addr;
  logic [7:0]  s_wdata;
`ifdef SPI_ARB_RR_EN
  assign tie = ~last_gnt;
`else
  assign tie = 1'b0;
`endif
  always_comb begin
    sel     = (bus.req0 & bus.req1) ? tie : bus.req1;
    s_rw    = sel ? bus.rw1 : bus.rw0;
    s_slv   = sel ? bus.slv1 : bus.slv0;
    s_addr  = sel ? bus.addr1 : bus.addr0;
    s_wdata = sel ? bus.wdata1 : bus.wdata0;
  end
  // The IDLE cycle is itself a cs-high cycle, so GAP only lasts GAP_CYCLES-1 cycles
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      last_gnt <= 1'b1;
      bit_cnt  <= 4'd0;
      gap_cnt  <= 4'd0;
      sr       <= 12'd0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (bus.req0 | bus.req1) begin
          state    <= SHIFT;
          cs       <= 1'b0;
          mosi     <= s_rw;
          sr       <= {s_slv, s_addr, s_wdata};
          bit_cnt  <= s_rw ? 4'd12 : 4'd4;
          last_gnt <= sel;
        end
        SHIFT: if (bit_cnt == 4'd0) begin
          state   <= (GAP_CYCLES > 1) ? GAP : IDLE;
          cs      <= 1'b1;
          mosi    <= 1'b0;
          ack0    <= ~last_gnt;
          ack1    <= last_gnt;
          gap_cnt <= 4'(GAP_CYCLES - 1);
        end else begin
          mosi    <= sr[11];
          sr      <= {sr[10:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt <= 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.cs       = cs;
  assign bus.mosi     = mosi;
  assign bus.ack0     = ack0;
  assign bus.ack1     = ack1;
  assign bus.last_gnt = last_gnt;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_spi_arb_master.sv
// tb_spi_arb_master: directed self-checking bench for spi_arb_master (GAP_CYCLES = 2)
module tb_spi_arb_master;
  logic sclk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  spi_arb_master_if bus ();
  spi_arb_master #(.GAP_CYCLES(2)) dut (.sclk(sclk), .reset(reset), .bus(bus));
  always #5 sclk = ~sclk;

  // Waits for cs low (counting cs-high cycles seen), then shifts in mosi until cs rises.
  task automatic capture(output logic [12:0] bits, output int len, output int waited,
                         output logic a0, output logic a1, output logic m, output logic ok);
    bits = '0; len = 0; waited = 0; a0 = 1'b0; a1 = 1'b0; m = 1'b0; ok = 1'b0;
    while (bus.cs && waited < 60) begin
      @(negedge sclk);
      waited++;
    end
    if (bus.cs) return;
    while (!bus.cs && len < 20) begin
      bits = {bits[11:0], bus.mosi};
      len++;
      @(negedge sclk);
    end
    a0 = bus.ack0; a1 = bus.ack1; m = bus.mosi; ok = bus.cs;
  endtask

  task automatic test_reset();
    logic [12:0] bits; int len, w; logic a0, a1, m, ok;
    checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL rst_cs got %b want 1", bus.cs); end
    checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", bus.mosi); end
    checks++; if ({bus.ack0, bus.ack1} !== 2'b00) begin errors++; $display("FAIL rst_ack got %b want 00", {bus.ack0, bus.ack1}); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.last_gnt !== 1'b1) begin errors++; $display("FAIL rst_last_gnt got %b want 1", bus.last_gnt); end
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.slv0 = 1'b1; bus.addr0 = 3'b000;
    @(negedge sclk);
    checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL rst_hold_cs got %b want 1", bus.cs); end
    reset = 1'b0;
    @(negedge sclk);
    checks++; if (bus.cs !== 1'b0) begin errors++; $display("FAIL first_grant_cs got %b want 0", bus.cs); end
    capture(bits, len, w, a0, a1, m, ok);
    bus.req0 = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_frame_timeout got %b want 1", ok); end
    checks++; if (bits[4:0] !== 5'b01000 || len != 5) begin errors++; $display("FAIL rst_frame got %b/%0d want 01000/5", bits[4:0], len); end
    checks++; if ({a0, a1} !== 2'b10) begin errors++; $display("FAIL rst_frame_ack got %b want 10", {a0, a1}); end
  endtask

  task automatic test_write();
    logic [12:0] bits; int len, w; logic a0, a1, m, ok;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.slv0 = 1'b0; bus.addr0 = 3'b010; bus.wdata0 = 8'h79;
    capture(bits, len, w, a0, a1, m, ok);
    bus.req0 = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_timeout got %b want 1", ok); end
    checks++; if (len != 13) begin errors++; $display("FAIL wr_len got %0d want 13", len); end
    checks++; if (bits !== 13'b1001001111001) begin errors++; $display("FAIL wr_bits got %b want 1001001111001", bits); end
    checks++; if ({a0, a1} !== 2'b10) begin errors++; $display("FAIL wr_ack got %b want 10", {a0, a1}); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL wr_mosi_idle got %b want 0", m); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_gap got %b want 1", bus.busy); end
    @(negedge sclk);
    checks++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", bus.ack0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] bits; int len, w; logic a0, a1, m, ok;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.slv1 = 1'b1; bus.addr1 = 3'b001; bus.wdata1 = 8'hFF;
    capture(bits, len, w, a0, a1, m, ok);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.slv0 = 1'b1; bus.addr0 = 3'b111; bus.wdata0 = 8'h0F;
    checks++; if (bits[4:0] !== 5'b01001 || len != 5) begin errors++; $display("FAIL rd_frame got %b/%0d want 01001/5", bits[4:0], len); end
    checks++; if ({a0, a1} !== 2'b01) begin errors++; $display("FAIL rd_ack got %b want 01", {a0, a1}); end
    checks++; if (bus.last_gnt !== 1'b1) begin errors++; $display("FAIL rd_last_gnt got %b want 1", bus.last_gnt); end
    capture(bits, len, w, a0, a1, m, ok);
    bus.req0 = 1'b0;
    checks++; if (w != 2) begin errors++; $display("FAIL b2b_gap got %0d want 2", w); end
    checks++; if (bits !== 13'b1111100001111 || len != 13) begin errors++; $display("FAIL b2b_frame got %b/%0d want 1111100001111/13", bits, len); end
    checks++; if ({a0, a1} !== 2'b10) begin errors++; $display("FAIL b2b_ack got %b want 10", {a0, a1}); end
  endtask

  task automatic test_tie();
    logic [12:0] bits; int len, w; logic a0, a1, m, ok; logic win;
    @(negedge sclk); reset = 1'b1;
    @(negedge sclk); reset = 1'b0;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.slv0 = 1'b0; bus.addr0 = 3'b011;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.slv1 = 1'b1; bus.addr1 = 3'b110;
    for (int k = 0; k < 4; k++) begin
`ifdef SPI_ARB_RR_EN
      win = k[0];
`else
      win = 1'b0;
`endif
      capture(bits, len, w, a0, a1, m, ok);
      if (k > 0) begin
        checks++; if (w != 2) begin errors++; $display("FAIL tie_gap%0d got %0d want 2", k, w); end
      end
      checks++; if ({a0, a1} !== {~win, win}) begin errors++; $display("FAIL tie_ack%0d got %b want %b", k, {a0, a1}, {~win, win}); end
      checks++; if (bits[4:0] !== (win ? 5'b01110 : 5'b00011)) begin errors++; $display("FAIL tie_bits%0d got %b win %b", k, bits[4:0], win); end
      checks++; if (bus.last_gnt !== win) begin errors++; $display("FAIL tie_last_gnt%0d got %b want %b", k, bus.last_gnt, win); end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [12:0] bits; int len, w; logic a0, a1, m, ok;
    int t;
    t = 0;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.slv0 = 1'b0; bus.addr0 = 3'b101; bus.wdata0 = 8'hFE;
    while (bus.cs && t < 60) begin @(negedge sclk); t++; end
    checks++; if (bus.cs !== 1'b0) begin errors++; $display("FAIL mid_start got %b want 0", bus.cs); end
    repeat (5) @(negedge sclk);
    checks++; if (bus.mosi !== 1'b1 || bus.cs !== 1'b0) begin errors++; $display("FAIL mid_bit6 got mosi %b cs %b want 1 0", bus.mosi, bus.cs); end
    bus.req0 = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL mid_async_cs got %b want 1", bus.cs); end
    checks++; if (bus.busy !== 1'b0 || bus.mosi !== 1'b0) begin errors++; $display("FAIL mid_busy_mosi got %b%b want 00", bus.busy, bus.mosi); end
    @(negedge sclk);
    reset = 1'b0;
    @(negedge sclk);
    checks++; if ({bus.ack0, bus.ack1, bus.cs} !== 3'b001) begin errors++; $display("FAIL mid_no_ack got %b want 001", {bus.ack0, bus.ack1, bus.cs}); end
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.slv1 = 1'b0; bus.addr1 = 3'b111;
    capture(bits, len, w, a0, a1, m, ok);
    bus.req1 = 1'b0;
    checks++; if (bits[4:0] !== 5'b00111 || len != 5) begin errors++; $display("FAIL mid_refrm got %b/%0d want 00111/5", bits[4:0], len); end
    checks++; if ({a0, a1} !== 2'b01) begin errors++; $display("FAIL mid_refrm_ack got %b want 01", {a0, a1}); end
  endtask

  task automatic test_field_change();
    logic [12:0] bits; int len, w; logic a0, a1, m, ok;
    int t;
    t = 0;
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.slv0 = 1'b1; bus.addr0 = 3'b100; bus.wdata0 = 8'hA5;
    @(negedge sclk);
    while (bus.cs && t < 60) begin @(negedge sclk); t++; end
    bus.addr0 = 3'b011; bus.wdata0 = 8'h00; bus.slv0 = 1'b0;
    capture(bits, len, w, a0, a1, m, ok);
    bus.req0 = 1'b0;
    checks++; if (bits !== 13'b1110010100101 || len != 13) begin errors++; $display("FAIL fld_bits got %b/%0d want 1110010100101/13", bits, len); end
    checks++; if ({a0, a1} !== 2'b10) begin errors++; $display("FAIL fld_ack got %b want 10", {a0, a1}); end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rw0 = 1'b0; bus.rw1 = 1'b0;
    bus.slv0 = 1'b0; bus.slv1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    @(negedge sclk);
    test_reset();
    test_write();
    test_back_to_back();
    test_tie();
    test_reset_mid();
    test_field_change();
    repeat (4) @(negedge sclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
